// File: rtl/io_uart_leds.sv
// IO-page slave: LED register, TX FIFO feeding an 8N1 UART serializer, and a status word.
// Optional receiver is built when IO_UART_RX_EN is defined.
module io_uart_leds #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned LED_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          IO_mem_addr,
    input  logic [31:0]          IO_mem_wdata,
    input  logic                 IO_mem_wr,
    output logic [31:0]          IO_mem_rdata,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic                 uart_txd,
    input  logic                 uart_rxd
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} txState_t;

    logic [2:0] idx;
    logic       wrLeds, wrData, wrStatus, wrAck;

    assign idx      = IO_mem_addr[4:2];
    assign wrLeds   = IO_mem_wr && (idx == 3'd0);
    assign wrData   = IO_mem_wr && (idx == 3'd1);
    assign wrStatus = IO_mem_wr && (idx == 3'd2);
    assign wrAck    = IO_mem_wr && (idx == 3'd3);

    logic [LED_WIDTH-1:0] ledReg;
    logic [7:0]           fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr, rdPtr;
    logic [PTR_W:0]       fifoCount;
    logic                 fifoEmpty, fifoFull, push, pushDrop, txPop;
    logic                 txOverflow;

    txState_t         txState;
    logic [CNT_W-1:0] baudCnt;
    logic [2:0]       bitCnt;
    logic [7:0]       txShift;
    logic             txdReg, lineBusy, txBusy;

    logic [7:0] rxData;
    logic       rxValid, rxOverrun, rxFrameErr;

    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == (PTR_W + 1)'(FIFO_DEPTH));
    // The serializer pops either from idle or on the last cycle of a stop bit (back-to-back).
    assign txPop     = !fifoEmpty &&
                       ((txState == TxIdle) || ((txState == TxStop) && (baudCnt == BIT_LAST)));
    assign push      = wrData && (!fifoFull || txPop);
    assign pushDrop  = wrData && fifoFull && !txPop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ledReg     <= '0;
            txOverflow <= 1'b0;
        end else begin
            if (wrLeds) ledReg <= IO_mem_wdata[LED_WIDTH-1:0];
            if (wrStatus && IO_mem_wdata[3]) txOverflow <= 1'b0;
            if (pushDrop) txOverflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= IO_mem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push)  wrPtr <= wrPtr + PTR_W'(1);
            if (txPop) rdPtr <= rdPtr + PTR_W'(1);
            if (push && !txPop)      fifoCount <= fifoCount + (PTR_W + 1)'(1);
            else if (!push && txPop) fifoCount <= fifoCount - (PTR_W + 1)'(1);
        end
    end

    // uart_txd is registered from the state, so the line trails the FSM by one cycle;
    // lineBusy keeps tx_busy high until the last stop cycle has left the pin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            txState  <= TxIdle;
            baudCnt  <= '0;
            bitCnt   <= '0;
            txShift  <= '0;
            txdReg   <= 1'b1;
            lineBusy <= 1'b0;
        end else begin
            lineBusy <= (txState != TxIdle);
            case (txState)
                TxIdle: begin
                    txdReg <= 1'b1;
                    if (txPop) begin
                        txShift <= fifoMem[rdPtr];
                        baudCnt <= '0;
                        txState <= TxStart;
                    end
                end
                TxStart: begin
                    txdReg <= 1'b0;
                    if (baudCnt == BIT_LAST) begin
                        baudCnt <= '0;
                        bitCnt  <= '0;
                        txState <= TxData;
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
                TxData: begin
                    txdReg <= txShift[0];
                    if (baudCnt == BIT_LAST) begin
                        baudCnt <= '0;
                        txShift <= {1'b0, txShift[7:1]};
                        if (bitCnt == 3'd7) txState <= TxStop;
                        else bitCnt <= bitCnt + 3'd1;
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
                TxStop: begin
                    txdReg <= 1'b1;
                    if (baudCnt == BIT_LAST) begin
                        baudCnt <= '0;
                        if (txPop) begin
                            txShift <= fifoMem[rdPtr];
                            txState <= TxStart;
                        end else begin
                            txState <= TxIdle;
                        end
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign txBusy   = !fifoEmpty || (txState != TxIdle) || lineBusy;
    assign uart_txd = txdReg;
    assign LEDS     = ledReg;

`ifdef IO_UART_RX_EN
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rxState_t;

    rxState_t         rxState;
    logic             rxSync1, rxSync2;
    logic [CNT_W-1:0] rxCnt;
    logic [2:0]       rxBitCnt;
    logic [7:0]       rxShift;

    // Flag sets are written after the clears so a same-cycle event wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxSync1    <= 1'b1;
            rxSync2    <= 1'b1;
            rxState    <= RxIdle;
            rxCnt      <= '0;
            rxBitCnt   <= '0;
            rxShift    <= '0;
            rxData     <= '0;
            rxValid    <= 1'b0;
            rxOverrun  <= 1'b0;
            rxFrameErr <= 1'b0;
        end else begin
            rxSync1 <= uart_rxd;
            rxSync2 <= rxSync1;
            if (wrAck) rxValid <= 1'b0;
            if (wrStatus && IO_mem_wdata[4]) rxOverrun <= 1'b0;
            if (wrStatus && IO_mem_wdata[5]) rxFrameErr <= 1'b0;
            case (rxState)
                RxIdle: begin
                    rxCnt <= '0;
                    if (!rxSync2) rxState <= RxStart;
                end
                RxStart: begin
                    if (rxCnt == HALF_LAST) begin
                        rxCnt    <= '0;
                        rxBitCnt <= '0;
                        rxState  <= rxSync2 ? RxIdle : RxData;
                    end else begin
                        rxCnt <= rxCnt + CNT_W'(1);
                    end
                end
                RxData: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt   <= '0;
                        rxShift <= {rxSync2, rxShift[7:1]};
                        if (rxBitCnt == 3'd7) rxState <= RxStop;
                        else rxBitCnt <= rxBitCnt + 3'd1;
                    end else begin
                        rxCnt <= rxCnt + CNT_W'(1);
                    end
                end
                RxStop: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt   <= '0;
                        rxState <= RxIdle;
                        if (rxSync2) begin
                            rxData  <= rxShift;
                            rxValid <= 1'b1;
                            if (rxValid) rxOverrun <= 1'b1;
                        end else begin
                            rxFrameErr <= 1'b1;
                        end
                    end else begin
                        rxCnt <= rxCnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end
`else
    assign rxData     = '0;
    assign rxValid    = 1'b0;
    assign rxOverrun  = 1'b0;
    assign rxFrameErr = 1'b0;

    logic unusedRx;
    assign unusedRx = ^{uart_rxd, wrAck};
`endif

    logic unusedBits;
    assign unusedBits = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata[31:8]};

    always_comb begin
        IO_mem_rdata = '0;
        unique case (idx)
            3'd0: IO_mem_rdata = 32'(ledReg);
            3'd1: IO_mem_rdata = {24'b0, rxData};
            3'd2: begin
                IO_mem_rdata[0]    = txBusy;
                IO_mem_rdata[1]    = fifoFull;
                IO_mem_rdata[2]    = rxValid;
                IO_mem_rdata[3]    = txOverflow;
                IO_mem_rdata[4]    = rxOverrun;
                IO_mem_rdata[5]    = rxFrameErr;
                IO_mem_rdata[15:8] = 8'(fifoCount);
            end
            default: IO_mem_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_io_uart_leds.sv
// Scoreboard bench for io_uart_leds (DIV=4): expected reads, line levels and TX frames are
// queued by the stimulus and popped by independent monitors.
module tb_io_uart_leds;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] IO_mem_addr, IO_mem_wdata, IO_mem_rdata;
    logic        IO_mem_wr, uart_txd, uart_rxd;
    logic [4:0]  LEDS;

    always #5 clk = ~clk;

    io_uart_leds #(
        .CLK_FREQ_HZ(400),
        .BAUD       (100),
        .FIFO_DEPTH (8),
        .LED_WIDTH  (5)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .IO_mem_addr (IO_mem_addr),
        .IO_mem_wdata(IO_mem_wdata),
        .IO_mem_wr   (IO_mem_wr),
        .IO_mem_rdata(IO_mem_rdata),
        .LEDS        (LEDS),
        .uart_txd    (uart_txd),
        .uart_rxd    (uart_rxd)
    );

    int          nTests = 0;
    int          nFail = 0;
    int          frameCnt = 0;
    int          rstEpoch = 0;
    logic        rdStrobe = 1'b0;
    logic [7:0]  txQ[$];
    logic [31:0] rdExpQ[$];
    string       rdNameQ[$];
    logic [1:0]  lineQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        IO_mem_addr  = a;
        IO_mem_wdata = d;
        IO_mem_wr    = 1'b1;
        @(posedge clk);
        #1 IO_mem_wr = 1'b0;
    endtask

    task automatic readReg(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        IO_mem_addr = a;
        rdNameQ.push_back(name);
        rdExpQ.push_back(exp);
        rdStrobe = 1'b1;
        #4 rdStrobe = 1'b0;
    endtask

    task automatic waitTxDrain(input int cycles);
        for (int i = 0; i < cycles && txQ.size() != 0; i++) @(posedge clk);
        check("tx frames drained", txQ.size(), 0);
    endtask

    task automatic sendRx(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        uart_rxd = 1'b0;
        #40;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            #40;
        end
        uart_rxd = stopBit;
        #40 uart_rxd = 1'b1;
        #100;
    endtask

    // Read-data monitor: combinational read sampled mid-phase while the strobe is up.
    always @(negedge clk) begin
        #2;
        if (rdStrobe) begin
            if (rdExpQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL read scoreboard: got 0x%08h, expected nothing", IO_mem_rdata);
            end else begin
                check(rdNameQ.pop_front(), IO_mem_rdata, rdExpQ.pop_front());
            end
        end
    end

    // Per-cycle line monitor: {txd, tx_busy} sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        logic [1:0] e;
        #1;
        if (lineQ.size() != 0) begin
            e = lineQ.pop_front();
            check("txd line level", 32'(uart_txd), 32'(e[1]));
            check("status tx_busy", 32'(IO_mem_rdata[0]), 32'(e[0]));
        end
    end

    // TX frame decoder: mid-bit sampling at 40 ns per bit.
    initial begin
        logic [7:0] b;
        logic       st, sp;
        int         ep;
        forever begin
            @(negedge uart_txd);
            ep = rstEpoch;
            #20 st = uart_txd;
            for (int i = 0; i < 8; i++) begin
                #40 b[i] = uart_txd;
            end
            #40 sp = uart_txd;
            if (ep != rstEpoch || resetn !== 1'b1) continue;
            frameCnt++;
            check("tx start bit", 32'(st), 0);
            check("tx stop bit", 32'(sp), 1);
            if (txQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL tx frame: got 0x%02h, expected no frame", b);
            end else begin
                check("tx frame data", 32'(b), 32'(txQ.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic       t;
        int         saved;

        resetn       = 1'b0;
        IO_mem_addr  = '0;
        IO_mem_wdata = '0;
        IO_mem_wr    = 1'b0;
        uart_rxd     = 1'b1;

        // Reset state, then idle after release
        repeat (2) @(posedge clk);
        #1;
        check("reset txd", 32'(uart_txd), 1);
        check("reset LEDS", 32'(LEDS), 0);
        readReg("reset status", 32'h8, 32'h0);
        @(negedge clk) resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("idle txd", 32'(uart_txd), 1);
        readReg("idle status", 32'h8, 32'h0);

        // LED register and unmapped words
        writeReg(32'h0, 32'h15);
        check("LEDS after write", 32'(LEDS), 32'h15);
        readReg("LEDS read", 32'h0, 32'h15);
        readReg("idx5 read", 32'h14, 32'h0);
        writeReg(32'h14, 32'hFF);
        readReg("idx3 read", 32'hC, 32'h0);
        readReg("LEDS after idx5 write", 32'h0, 32'h15);
        writeReg(32'h0, 32'hFFFF_FFEA);
        check("LEDS masked", 32'(LEDS), 32'h0A);
        readReg("LEDS masked read", 32'h0, 32'h0A);

        // Single frame timing: write at edge n, check edges n+1..n+44
        pat = 8'h55;
        txQ.push_back(pat);
        writeReg(32'h4, 32'h55);
        @(negedge clk);
        IO_mem_addr = 32'h8;
        for (int k = 1; k <= 44; k++) begin
            if (k >= 2 && k <= 5) t = 1'b0;
            else if (k >= 6 && k <= 37) t = pat[(k - 6) / 4];
            else t = 1'b1;
            lineQ.push_back({t, (k <= 41)});
        end
        for (int i = 0; i < 60 && lineQ.size() != 0; i++) @(posedge clk);
        check("line checks consumed", lineQ.size(), 0);
        waitTxDrain(60);

        // Burst of 10 writes: one in flight, 8 queued, 10th dropped
        for (int i = 0; i < 10; i++) begin
            if (i < 9) txQ.push_back(8'(8'h10 + i));
            writeReg(32'h4, 32'(8'h10 + i));
        end
        readReg("status full+overflow", 32'h8, 32'h0000_080B);
        writeReg(32'h8, 32'h8);
        readReg("status overflow cleared", 32'h8, 32'h0000_0803);
        waitTxDrain(600);
        repeat (10) @(posedge clk);
        readReg("status after burst", 32'h8, 32'h0);

        // Reset mid-DATA
        txQ.push_back(8'h33);
        writeReg(32'h4, 32'h33);
        repeat (15) @(posedge clk);
        #3 resetn = 1'b0;
        rstEpoch++;
        txQ.delete();
        #1 check("txd on async reset", 32'(uart_txd), 1);
        check("LEDS on async reset", 32'(LEDS), 0);
        readReg("status in reset", 32'h8, 32'h0);
        @(negedge clk) resetn = 1'b1;
        saved = frameCnt;
        repeat (100) @(posedge clk);
        check("no frame after reset", frameCnt, saved);
        readReg("status after reset", 32'h8, 32'h0);

`ifdef IO_UART_RX_EN
        sendRx(8'hA5, 1'b1);
        readReg("rx_valid", 32'h8, 32'h04);
        readReg("rx data A5", 32'h4, 32'hA5);
        sendRx(8'h3C, 1'b1);
        readReg("rx_overrun", 32'h8, 32'h14);
        readReg("rx data 3C", 32'h4, 32'h3C);
        sendRx(8'h77, 1'b0);
        readReg("rx_frame_err", 32'h8, 32'h34);
        readReg("rx data kept", 32'h4, 32'h3C);
        @(negedge clk) uart_rxd = 1'b0;
        #10 uart_rxd = 1'b1;
        #100;
        readReg("status after glitch", 32'h8, 32'h34);
        writeReg(32'hC, 32'h0);
        readReg("rx_valid acked", 32'h8, 32'h30);
        writeReg(32'h8, 32'h30);
        readReg("rx flags cleared", 32'h8, 32'h0);
`else
        sendRx(8'hA5, 1'b1);
        readReg("rx disabled status", 32'h8, 32'h0);
        readReg("rx disabled data", 32'h4, 32'h0);
        writeReg(32'hC, 32'h1);
        readReg("rx disabled after ack", 32'h8, 32'h0);
`endif

        waitTxDrain(10);
        check("read scoreboard empty", rdExpQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
